delta_lif_core: RTL and testbench

//  Parametrised leaky integrate-and-fire neuron with a lossless delta-event encoder.

---
 rtl/delta_lif_core.sv | 141 ++++++++++++++
 tb/tb_delta_lif_core.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/delta_lif_core.sv
// Leaky integrate-and-fire neuron with subtractive reset, refractory period and a lossless delta-event encoder.
// Latency: a step sampled at one edge updates state_out/spike on that edge; the resulting event is raised one edge later.
// Backpressure: ev_data holds while ev_valid & !ev_ready; ref only advances on accept, so no membrane change is lost.
module delta_lif_core #(
    parameter int WIDTH      = 8,
    parameter int LEAK_SHIFT = 1,
    parameter int REF_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_current,
    input  logic [WIDTH-1:0] cfg_vth,
    input  logic [WIDTH-1:0] cfg_delta,
    input  logic [REF_W-1:0] cfg_refrac,
    output logic [WIDTH-1:0] state_out,
    output logic             spike,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [WIDTH:0]   ev_data,
    output logic             refrac
);

    localparam logic [0:0] ST_INTEGRATE  = 1'b0;
    localparam logic [0:0] ST_REFRACTORY = 1'b1;
    localparam logic [0:0] ENC_IDLE      = 1'b0;
    localparam logic [0:0] ENC_HOLD      = 1'b1;

    localparam logic [REF_W-1:0] CNT_ONE   = 1;
    localparam logic [WIDTH:0]   DATA_ZERO = '0;

    // neuron state
    logic [WIDTH-1:0] u_q;
    logic [WIDTH-1:0] u_n;
    logic [REF_W-1:0] refrac_cnt;
    logic [REF_W-1:0] cnt_n;
    logic [0:0]       ns_q;
    logic [0:0]       ns_n;
    logic             spike_q;
    logic             spike_n;

    logic [WIDTH-1:0] leak;
    logic [WIDTH-1:0] decayed;
    logic [WIDTH:0]   sum_w;
    logic [WIDTH-1:0] sum_sat;
    logic             fire;

    // encoder state
    logic [0:0]       enc_q;
    logic [0:0]       enc_n;
    logic [WIDTH-1:0] ref_q;
    logic [WIDTH-1:0] ref_n;
    logic [WIDTH:0]   ref_sum;
    logic [WIDTH:0]   ev_data_q;
    logic [WIDTH:0]   ev_data_n;
    logic [WIDTH:0]   d;
    logic [WIDTH:0]   abs_d;
    logic             accept;
    logic             load;

    always_comb begin
        leak    = u_q >> LEAK_SHIFT;
        decayed = u_q - leak;
        sum_w   = {1'b0, decayed} + {1'b0, in_current};
        sum_sat = sum_w[WIDTH] ? {WIDTH{1'b1}} : sum_w[WIDTH-1:0];
        fire    = (cfg_vth != '0) && (sum_sat >= cfg_vth);

        u_n     = u_q;
        cnt_n   = refrac_cnt;
        spike_n = 1'b0;

        if (in_valid) begin
            if (ns_q == ST_REFRACTORY) begin
                // input current is dropped while refractory; only the leak applies
                u_n   = decayed;
                cnt_n = refrac_cnt - CNT_ONE;
            end else if (fire) begin
                u_n     = sum_sat - cfg_vth;
                spike_n = 1'b1;
                cnt_n   = cfg_refrac;
            end else begin
                u_n = sum_sat;
            end
        end

        ns_n = (cnt_n != '0) ? ST_REFRACTORY : ST_INTEGRATE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            u_q        <= '0;
            refrac_cnt <= '0;
            ns_q       <= ST_INTEGRATE;
            spike_q    <= 1'b0;
        end else begin
            u_q        <= u_n;
            refrac_cnt <= cnt_n;
            ns_q       <= ns_n;
            spike_q    <= spike_n;
        end
    end

    always_comb begin
        accept  = (enc_q == ENC_HOLD) && ev_ready;
        ref_sum = {1'b0, ref_q} + ev_data_q;
        // ref + accepted delta always lands back in the unsigned membrane range
        ref_n   = accept ? ref_sum[WIDTH-1:0] : ref_q;
        d       = {1'b0, u_q} - {1'b0, ref_n};
        abs_d   = d[WIDTH] ? (DATA_ZERO - d) : d;
        load    = ((enc_q == ENC_IDLE) || ev_ready) && (d != DATA_ZERO) &&
                  (abs_d >= {1'b0, cfg_delta});

        enc_n     = enc_q;
        ev_data_n = ev_data_q;
        if (load) begin
            enc_n     = ENC_HOLD;
            ev_data_n = d;
        end else if (accept) begin
            enc_n = ENC_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enc_q     <= ENC_IDLE;
            ref_q     <= '0;
            ev_data_q <= '0;
        end else begin
            enc_q     <= enc_n;
            ref_q     <= ref_n;
            ev_data_q <= ev_data_n;
        end
    end

    assign state_out = u_q;
    assign spike     = spike_q;
    assign refrac    = (ns_q == ST_REFRACTORY);
    assign ev_valid  = (enc_q == ENC_HOLD);
    assign ev_data   = ev_data_q;

endmodule

// File: tb/tb_delta_lif_core.sv
// Directed bench for delta_lif_core: reset, leak/saturation, firing/refractory, delta events, backpressure, idle hold.
module tb_delta_lif_core;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_current;
    logic [7:0] cfg_vth;
    logic [7:0] cfg_delta;
    logic [3:0] cfg_refrac;
    logic [7:0] state_out;
    logic       spike;
    logic       ev_valid;
    logic       ev_ready;
    logic [8:0] ev_data;
    logic       refrac;

    int checks = 0;
    int errors = 0;
    int ev_sum = 0;

    delta_lif_core #(.WIDTH(8), .LEAK_SHIFT(1), .REF_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_current (in_current),
        .cfg_vth    (cfg_vth),
        .cfg_delta  (cfg_delta),
        .cfg_refrac (cfg_refrac),
        .state_out  (state_out),
        .spike      (spike),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_data    (ev_data),
        .refrac     (refrac)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int cur);
        in_valid   = 1'b1;
        in_current = cur[7:0];
        tick();
        in_valid   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    int t4_cur [10] = '{20, 20, 20, 20, 20, 20, 0, 0, 0, 0};
    int t4_u   [10] = '{20, 30, 35, 38, 39, 40, 20, 10, 5, 3};
    int t4_ev  [10] = '{20, 10, 0, 0, 0, 10, -20, -10, 0, 0};

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_current = '0;
        cfg_vth    = '0;
        cfg_delta  = 8'd1;
        cfg_refrac = '0;
        ev_ready   = 1'b0;
        #1;
        chk("rst_u",        int'(state_out), 0);
        chk("rst_spike",    int'(spike), 0);
        chk("rst_ev_valid", int'(ev_valid), 0);
        chk("rst_ev_data",  int'(ev_data), 0);
        chk("rst_refrac",   int'(refrac), 0);
        tick();
        tick();
        rst = 1'b0;

        // T1: reset in the middle of a stalled handshake
        step(50);
        chk("t1_u", int'(state_out), 50);
        tick();
        chk("t1_ev_valid", int'(ev_valid), 1);
        chk("t1_ev_data",  $signed(ev_data), 50);
        #2 rst = 1'b1;
        #1;
        chk("t1_async_ev_valid", int'(ev_valid), 0);
        chk("t1_async_ev_data",  int'(ev_data), 0);
        chk("t1_async_u",        int'(state_out), 0);
        tick();
        tick();
        rst      = 1'b0;
        ev_ready = 1'b1;
        tick();
        tick();
        chk("t1_post_ev_valid", int'(ev_valid), 0);
        chk("t1_post_u",        int'(state_out), 0);

        // T2: leak and saturation, firing disabled
        do_reset();
        cfg_vth = '0;
        step(200); chk("t2_u200", int'(state_out), 200);
        step(200); chk("t2_sat",  int'(state_out), 255);
        chk("t2_nospike", int'(spike), 0);
        step(0);   chk("t2_leak128", int'(state_out), 128);
        step(0);   chk("t2_leak64",  int'(state_out), 64);
        step(0);   chk("t2_leak32",  int'(state_out), 32);

        // T3: fire, subtractive reset, refractory
        do_reset();
        cfg_vth    = 8'd100;
        cfg_refrac = 4'd2;
        step(60); chk("t3_u60", int'(state_out), 60); chk("t3_spk0", int'(spike), 0);
        step(60); chk("t3_u90", int'(state_out), 90);
        step(60);
        chk("t3_fire_u",   int'(state_out), 5);
        chk("t3_fire_spk", int'(spike), 1);
        chk("t3_fire_ref", int'(refrac), 1);
        tick();
        chk("t3_spk_pulse", int'(spike), 0);
        chk("t3_hold_u",    int'(state_out), 5);
        step(60); chk("t3_ref_u3", int'(state_out), 3); chk("t3_ref1", int'(refrac), 1);
        step(60); chk("t3_ref_u2", int'(state_out), 2); chk("t3_ref0", int'(refrac), 0);
        step(60); chk("t3_u61", int'(state_out), 61); chk("t3_spk_after", int'(spike), 0);

        // T4: delta encoding with a free-running consumer
        do_reset();
        cfg_vth   = '0;
        cfg_refrac = '0;
        cfg_delta = 8'd10;
        ev_ready  = 1'b1;
        ev_sum    = 0;
        for (int i = 0; i < 10; i++) begin
            step(t4_cur[i]);
            chk($sformatf("t4_u%0d", i), int'(state_out), t4_u[i]);
            tick();
            if (t4_ev[i] != 0) begin
                chk($sformatf("t4_ev_valid%0d", i), int'(ev_valid), 1);
                chk($sformatf("t4_ev_data%0d", i), $signed(ev_data), t4_ev[i]);
            end else begin
                chk($sformatf("t4_ev_none%0d", i), int'(ev_valid), 0);
            end
            if (ev_valid) ev_sum += $signed(ev_data);
            tick();
        end
        chk("t4_sum", ev_sum, 10);
        cfg_delta = '0;
        tick();
        chk("t4_d0_valid", int'(ev_valid), 1);
        chk("t4_d0_data",  $signed(ev_data), -7);
        if (ev_valid) ev_sum += $signed(ev_data);
        tick();
        chk("t4_d0_idle", int'(ev_valid), 0);
        chk("t4_sum_tracks_u", ev_sum, 3);
        chk("t4_u_final", int'(state_out), 3);

        // T5: backpressure, then back-to-back catch-up event
        do_reset();
        cfg_delta = 8'd1;
        ev_ready  = 1'b0;
        step(30);
        chk("t5_u30", int'(state_out), 30);
        tick();
        chk("t5_valid", int'(ev_valid), 1);
        chk("t5_data",  $signed(ev_data), 30);
        for (int i = 0; i < 6; i++) begin
            step(40);
            chk($sformatf("t5_hold%0d", i), $signed(ev_data), 30);
            chk($sformatf("t5_hold_v%0d", i), int'(ev_valid), 1);
        end
        chk("t5_u80", int'(state_out), 80);
        ev_ready = 1'b1;
        tick();
        chk("t5_b2b_valid", int'(ev_valid), 1);
        chk("t5_b2b_data",  $signed(ev_data), 50);
        tick();
        chk("t5_drained", int'(ev_valid), 0);

        // T6: long idle with a pending event and an active refractory count
        do_reset();
        cfg_vth    = 8'd100;
        cfg_refrac = 4'd3;
        cfg_delta  = 8'd1;
        ev_ready   = 1'b0;
        step(60);
        step(60);
        step(60);
        chk("t6_fire_u",   int'(state_out), 5);
        chk("t6_fire_spk", int'(spike), 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("t6_u%0d", i),     int'(state_out), 5);
            chk($sformatf("t6_ref%0d", i),   int'(refrac), 1);
            chk($sformatf("t6_spk%0d", i),   int'(spike), 0);
            chk($sformatf("t6_valid%0d", i), int'(ev_valid), 1);
            chk($sformatf("t6_data%0d", i),  $signed(ev_data), 60);
        end
        step(60); chk("t6_u3", int'(state_out), 3); chk("t6_ref_a", int'(refrac), 1);
        step(60); chk("t6_u2", int'(state_out), 2); chk("t6_ref_b", int'(refrac), 1);
        step(60); chk("t6_u1", int'(state_out), 1); chk("t6_ref_c", int'(refrac), 0);
        ev_ready = 1'b1;
        tick();
        chk("t6_b2b_valid", int'(ev_valid), 1);
        chk("t6_b2b_data",  $signed(ev_data), -59);
        tick();
        chk("t6_drained", int'(ev_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
